// File: rtl/password_entry.sv
`default_nettype none
// ============================================================================
// Module   : password_entry
// Purpose  : Keypad front end for the access control block. Collects four
//            4-bit digits into an 18-bit password word, issues it with a
//            one-cycle load strobe, waits a bounded time for the grant
//            response, tracks the granted session and applies a timed
//            lockout after repeated consecutive failures.
// Ports    : clk             - system clock, rising edge
//            rst             - asynchronous active-low reset
//            digit_in        - keypad digit, valid with digit_load
//            digit_load      - one-cycle digit strobe
//            user_id         - user select, captured with the first digit
//            clear_entry     - one-cycle strobe, discards a partial entry
//            logout          - one-cycle strobe, ends a granted session
//            access_grant_in - grant level from access control
//            data_out        - password word {user, d1, d2, d3, d4}
//            data_out_load   - one-cycle load strobe for data_out
//            digit_count     - digits held in the current entry (0..4)
//            session_active  - high while access is granted
//            locked          - high during lockout
// Revision : 1.0 - initial release
// ============================================================================
module password_entry #(
  parameter int RESP_WAIT      = 8,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_in,
  input  logic        digit_load,
  input  logic [1:0]  user_id,
  input  logic        clear_entry,
  input  logic        logout,
  input  logic        access_grant_in,
  output logic [17:0] data_out,
  output logic        data_out_load,
  output logic [2:0]  digit_count,
  output logic        session_active,
  output logic        locked
);

  localparam logic [7:0]  RESP_LOAD  = 8'(RESP_WAIT);
  localparam logic [2:0]  FAIL_LIMIT = 3'(MAX_FAILS);
  localparam logic [15:0] LOCK_LOAD  = 16'(LOCKOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COLLECT   = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_GRANTED   = 3'd4,
    S_LOCKOUT   = 3'd5
  } state_t;

  state_t      state_q,       state_d;
  logic [17:0] data_out_q,    data_out_d;
  logic [2:0]  digit_count_q, digit_count_d;
  logic [2:0]  fail_cnt_q,    fail_cnt_d;
  logic [7:0]  resp_cnt_q,    resp_cnt_d;
  logic [15:0] lock_cnt_q,    lock_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      data_out_q    <= '0;
      digit_count_q <= '0;
      fail_cnt_q    <= '0;
      resp_cnt_q    <= '0;
      lock_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      data_out_q    <= data_out_d;
      digit_count_q <= digit_count_d;
      fail_cnt_q    <= fail_cnt_d;
      resp_cnt_q    <= resp_cnt_d;
      lock_cnt_q    <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    data_out_d    = data_out_q;
    digit_count_d = digit_count_q;
    fail_cnt_d    = fail_cnt_q;
    resp_cnt_d    = resp_cnt_q;
    lock_cnt_d    = lock_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (digit_load) begin
          data_out_d    = {user_id, digit_in, 12'h000};
          digit_count_d = 3'd1;
          state_d       = S_COLLECT;
        end
      end

      S_COLLECT: begin
        // Clear has priority: a digit arriving with clear is dropped.
        if (clear_entry) begin
          data_out_d    = '0;
          digit_count_d = '0;
          state_d       = S_IDLE;
        end else if (digit_load) begin
          case (digit_count_q)
            3'd1:    data_out_d[11:8] = digit_in;
            3'd2:    data_out_d[7:4]  = digit_in;
            default: data_out_d[3:0]  = digit_in;
          endcase
          digit_count_d = digit_count_q + 3'd1;
          if (digit_count_q == 3'd3) begin
            state_d = S_SEND;
          end
        end
      end

      S_SEND: begin
        resp_cnt_d = RESP_LOAD;
        state_d    = S_WAIT_RESP;
      end

      S_WAIT_RESP: begin
        // Grant wins even on the final sampled edge of the window.
        if (access_grant_in) begin
          fail_cnt_d = '0;
          resp_cnt_d = '0;
          state_d    = S_GRANTED;
        end else if (resp_cnt_q <= 8'd1) begin
          resp_cnt_d    = '0;
          data_out_d    = '0;
          digit_count_d = '0;
          if (fail_cnt_q >= FAIL_LIMIT - 3'd1) begin
            fail_cnt_d = FAIL_LIMIT;
            lock_cnt_d = LOCK_LOAD;
            state_d    = S_LOCKOUT;
          end else begin
            fail_cnt_d = fail_cnt_q + 3'd1;
            state_d    = S_IDLE;
          end
        end else begin
          resp_cnt_d = resp_cnt_q - 8'd1;
        end
      end

      S_GRANTED: begin
        if (logout) begin
          data_out_d    = '0;
          digit_count_d = '0;
          state_d       = S_IDLE;
        end
      end

      S_LOCKOUT: begin
        if (lock_cnt_q <= 16'd1) begin
          lock_cnt_d = '0;
          fail_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q - 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobe and status outputs decode the state register directly, so they
  // are registered and clear asynchronously with it.
  assign data_out       = data_out_q;
  assign digit_count    = digit_count_q;
  assign data_out_load  = (state_q == S_SEND);
  assign session_active = (state_q == S_GRANTED);
  assign locked         = (state_q == S_LOCKOUT);

endmodule
`default_nettype wire

// File: tb/tb_password_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_password_entry
// Purpose  : Self-checking bench for password_entry. A table of cycle
//            vectors, hand-written multi-cycle sequences (reject, lockout,
//            asynchronous reset) and a randomized phase, all checked against
//            a queue-based behavioural model of the entry/session rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_password_entry;

  localparam int RESP_WAIT      = 8;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 16;

  logic        clk;
  logic        rst;
  logic [3:0]  digit_in;
  logic        digit_load;
  logic [1:0]  user_id;
  logic        clear_entry;
  logic        logout;
  logic        access_grant_in;
  logic [17:0] data_out;
  logic        data_out_load;
  logic [2:0]  digit_count;
  logic        session_active;
  logic        locked;

  logic [23:0] act;
  assign act = {data_out, data_out_load, digit_count, session_active, locked};

  int checks = 0;
  int errors = 0;

  password_entry #(
    .RESP_WAIT      (RESP_WAIT),
    .MAX_FAILS      (MAX_FAILS),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .digit_in        (digit_in),
    .digit_load      (digit_load),
    .user_id         (user_id),
    .clear_entry     (clear_entry),
    .logout          (logout),
    .access_grant_in (access_grant_in),
    .data_out        (data_out),
    .data_out_load   (data_out_load),
    .digit_count     (digit_count),
    .session_active  (session_active),
    .locked          (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // The entry is a queue of digits; the phases are remaining-cycle counts.
  int m_dig[$];
  int m_user;
  bit m_load;
  int m_wait;
  bit m_gr;
  int m_lock;
  int m_fails;

  task automatic model_reset();
    m_dig.delete();
    m_user  = 0;
    m_load  = 0;
    m_wait  = 0;
    m_gr    = 0;
    m_lock  = 0;
    m_fails = 0;
  endtask

  task automatic model_step();
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (m_gr) begin
      if (logout) begin
        m_gr = 0;
        m_dig.delete();
      end
    end else if (m_load) begin
      m_load = 0;
      m_wait = RESP_WAIT;
    end else if (m_wait > 0) begin
      if (access_grant_in) begin
        m_gr    = 1;
        m_fails = 0;
        m_wait  = 0;
      end else begin
        m_wait--;
        if (m_wait == 0) begin
          m_dig.delete();
          m_fails++;
          if (m_fails >= MAX_FAILS) begin
            m_fails = MAX_FAILS;
            m_lock  = LOCKOUT_CYCLES;
          end
        end
      end
    end else begin
      if (m_dig.size() > 0 && clear_entry) begin
        m_dig.delete();
      end else if (digit_load) begin
        if (m_dig.size() == 0) m_user = int'(user_id);
        m_dig.push_back(int'(digit_in));
        if (m_dig.size() == 4) m_load = 1;
      end
    end
  endtask

  function automatic logic [23:0] model_out();
    logic [17:0] w;
    w = '0;
    if (m_dig.size() > 0) w = 18'(m_user) << 16;
    foreach (m_dig[i]) w = w | (18'(m_dig[i]) << (12 - 4 * i));
    return {w, 1'(m_load), 3'(m_dig.size()), 1'(m_gr), 1'(m_lock > 0)};
  endfunction

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [23:0] a, input logic [23:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
    end
  endtask

  task automatic drv(input logic dl, input logic [3:0] d, input logic [1:0] u,
                     input logic clr, input logic lo, input logic g);
    digit_load      = dl;
    digit_in        = d;
    user_id         = u;
    clear_entry     = clr;
    logout          = lo;
    access_grant_in = g;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model", act, model_out());
  endtask

  task automatic enter(input logic [1:0] u, input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, code[15 - 4 * i -: 4], u, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drv(1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reject(input logic [1:0] u, input logic [15:0] code);
    enter(u, code);
    repeat (RESP_WAIT + 1) tick();
  endtask

  // Asserts rst between clock edges and checks outputs before any edge.
  task automatic async_reset(input string name);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk(name, act, 24'h0);
    @(posedge clk);
    #1;
    chk({name, "_hold"}, act, 24'h0);
    #2;
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic        dl;
    logic [3:0]  d;
    logic [1:0]  u;
    logic        clr;
    logic        lo;
    logic        g;
    logic [23:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic dl, input logic [3:0] d, input logic [1:0] u,
                              input logic clr, input logic lo, input logic g,
                              input logic [17:0] dat, input logic ld, input logic [2:0] cnt,
                              input logic ses, input logic lk);
    vec_t v;
    v.dl = dl; v.d = d; v.u = u; v.clr = clr; v.lo = lo; v.g = g;
    v.exp = {dat, ld, cnt, ses, lk};
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    int n;
    logic [15:0] code;

    // grant path, session with ignored strobes, logout
    tbl[0]  = mk(1, 4'h1, 2'd1, 0, 0, 0, 18'h11000, 0, 3'd1, 0, 0);
    tbl[1]  = mk(1, 4'h2, 2'd1, 0, 0, 0, 18'h11200, 0, 3'd2, 0, 0);
    tbl[2]  = mk(1, 4'h3, 2'd1, 0, 0, 0, 18'h11230, 0, 3'd3, 0, 0);
    tbl[3]  = mk(1, 4'h4, 2'd1, 0, 0, 0, 18'h11234, 1, 3'd4, 0, 0);
    tbl[4]  = mk(0, 4'h0, 2'd0, 0, 0, 0, 18'h11234, 0, 3'd4, 0, 0);
    tbl[5]  = mk(0, 4'h0, 2'd0, 0, 0, 0, 18'h11234, 0, 3'd4, 0, 0);
    tbl[6]  = mk(0, 4'h0, 2'd0, 0, 0, 1, 18'h11234, 0, 3'd4, 1, 0);
    tbl[7]  = mk(1, 4'h9, 2'd2, 0, 0, 0, 18'h11234, 0, 3'd4, 1, 0);
    tbl[8]  = mk(0, 4'h0, 2'd0, 1, 0, 0, 18'h11234, 0, 3'd4, 1, 0);
    tbl[9]  = mk(0, 4'h0, 2'd0, 0, 1, 0, 18'h00000, 0, 3'd0, 0, 0);
    // clear colliding with a digit, then a fresh entry
    tbl[10] = mk(1, 4'h5, 2'd2, 0, 0, 0, 18'h25000, 0, 3'd1, 0, 0);
    tbl[11] = mk(1, 4'h6, 2'd2, 0, 0, 0, 18'h25600, 0, 3'd2, 0, 0);
    tbl[12] = mk(1, 4'h7, 2'd2, 1, 0, 0, 18'h00000, 0, 3'd0, 0, 0);
    tbl[13] = mk(1, 4'h8, 2'd3, 0, 0, 0, 18'h38000, 0, 3'd1, 0, 0);
    tbl[14] = mk(1, 4'h9, 2'd3, 0, 0, 0, 18'h38900, 0, 3'd2, 0, 0);
    tbl[15] = mk(1, 4'hA, 2'd3, 0, 0, 0, 18'h389A0, 0, 3'd3, 0, 0);
    tbl[16] = mk(1, 4'hB, 2'd3, 0, 0, 0, 18'h389AB, 1, 3'd4, 0, 0);
    // grant during the load cycle is not sampled; the next edge is
    tbl[17] = mk(0, 4'h0, 2'd0, 0, 0, 1, 18'h389AB, 0, 3'd4, 0, 0);
    tbl[18] = mk(0, 4'h0, 2'd0, 0, 0, 1, 18'h389AB, 0, 3'd4, 1, 0);
    tbl[19] = mk(0, 4'h0, 2'd0, 0, 1, 0, 18'h00000, 0, 3'd0, 0, 0);

    // ------------------------------------------------------------ reset
    rst = 1'b0;
    drv(1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    chk("reset_state", act, 24'h0);
    @(posedge clk);
    #1;
    chk("reset_held", act, 24'h0);
    #2;
    rst = 1'b1;

    // ------------------------------------------------------------ table
    for (int i = 0; i < 20; i++) begin
      drv(tbl[i].dl, tbl[i].d, tbl[i].u, tbl[i].clr, tbl[i].lo, tbl[i].g);
      tick();
      chk($sformatf("vec%0d", i), act, tbl[i].exp);
    end
    drv(1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);

    // ------------------------------------------------------------ reject
    enter(2'd0, 16'hABCD);
    chk("rej_load", act, {18'h0ABCD, 1'b1, 3'd4, 1'b0, 1'b0});
    for (int k = 1; k <= RESP_WAIT + 1; k++) begin
      tick();
      if (k <= RESP_WAIT)
        chk($sformatf("rej_wait%0d", k), act, {18'h0ABCD, 1'b0, 3'd4, 1'b0, 1'b0});
      else
        chk("rej_idle", act, 24'h0);
    end

    // ------------------------------------------------------------ reset mid-wait
    reject(2'd0, 16'h1111);        // second consecutive failure
    enter(2'd0, 16'h2222);
    tick();
    tick();                          // now inside the response window
    async_reset("rst_wait");
    reject(2'd0, 16'h3333);
    reject(2'd0, 16'h4444);
    chk("fails_cleared_wait", {23'd0, locked}, 24'd0);

    // ------------------------------------------------------------ lockout
    reject(2'd1, 16'h5555);          // third consecutive failure
    chk("lock_enter", act, {18'h0, 1'b0, 3'd0, 1'b0, 1'b1});
    n = 0;
    while (locked && n < 100) begin
      drv(1'b1, 4'($urandom_range(15)), 2'($urandom_range(3)),
          1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      tick();
      n++;
      if (n < LOCKOUT_CYCLES)
        chk("lock_ignore", act, {18'h0, 1'b0, 3'd0, 1'b0, 1'b1});
    end
    chk("lock_len", 24'(n), 24'(LOCKOUT_CYCLES));
    drv(1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    enter(2'd1, 16'h1234);
    tick();
    drv(1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("post_lock_grant", act, {18'h11234, 1'b0, 3'd4, 1'b1, 1'b0});
    drv(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("logout", act, 24'h0);
    drv(1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);

    // ------------------------------------------------------------ reset mid-lockout
    reject(2'd2, 16'h6666);
    reject(2'd2, 16'h7777);
    reject(2'd2, 16'h8888);
    chk("lock_again", {23'd0, locked}, 24'd1);
    repeat (5) tick();
    async_reset("rst_lock");
    reject(2'd2, 16'h9999);
    chk("fails_cleared_lock", {23'd0, locked}, 24'd0);

    // ------------------------------------------------------------ random
    for (int c = 0; c < 2500; c++) begin
      code = 16'($urandom);
      drv(1'($urandom_range(2) == 0), code[3:0], code[5:4],
          1'($urandom_range(9) == 0), 1'($urandom_range(5) == 0),
          1'($urandom_range(11) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/password_entry.md
# password_entry

Front-end producer for the access control block. Collects four 4-bit keypad digits, one per `digit_load` strobe, into the 18-bit password word and issues it with a one-cycle load pulse. It then waits a bounded time for the grant response and tracks the resulting login session. Consecutive failed attempts are counted, and repeated failures trigger a timed lockout.

## Interface
Parameters:
- `RESP_WAIT`, 8: cycles to wait for `access_grant_in` after the load pulse; must cover ROM/RAM read plus compare latency; legal range 1..255.
- `MAX_FAILS`, 3: consecutive failed attempts that trigger lockout; legal range 1..7.
- `LOCKOUT_CYCLES`, 16: lockout duration in clock cycles; legal range 1..65535.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low; all state and outputs clear immediately.
- `digit_in`  in  4  keypad digit; sampled only when `digit_load`=1.
- `digit_load`  in  1  one-cycle strobe from the debounced enter button.
- `user_id`  in  2  user select; sampled together with the first digit of an entry.
- `clear_entry`  in  1  one-cycle strobe; discards a partial entry.
- `logout`  in  1  one-cycle strobe; ends a granted session.
- `access_grant_in`  in  1  grant level from access control.
- `data_out`  out  18  password word to access control.
- `data_out_load`  out  1  one-cycle load strobe to access control.
- `digit_count`  out  3  digits held in the current entry, 0..4.
- `session_active`  out  1  high while access is granted.
- `locked`  out  1  high during lockout.

## Operation
- Word format of `data_out`:
  - [17:16] = `user_id` sampled with digit 1.
  - [15:12] = digit 1, [11:8] = digit 2, [7:4] = digit 3, [3:0] = digit 4.
  - Unused nibbles hold 0 while the entry is partial.
- States and transitions:
  - IDLE:
    - `digit_load` stores digit 1 and `user_id`, sets `digit_count`=1, goes to COLLECT.
    - `clear_entry` and `logout` have no effect.
  - COLLECT:
    - Each `digit_load` stores the next digit and increments `digit_count`.
    - On digit 4, go to SEND.
    - `clear_entry` zeroes `data_out` and `digit_count` and returns to IDLE.
    - If `clear_entry` and `digit_load` arrive in the same cycle, clear wins and the digit is dropped.
  - SEND: exactly one cycle; `data_out_load`=1; then WAIT_RESP.
  - WAIT_RESP:
    - Loads the response counter with `RESP_WAIT`.
    - Samples `access_grant_in` each edge. Grant high on any sampled edge: go to GRANTED and clear the fail count.
    - Counter expiry with no grant: increment the fail count, zero `data_out` and `digit_count`.
    - After a failure, go to LOCKOUT if the fail count equals `MAX_FAILS`, otherwise to IDLE.
  - GRANTED:
    - `session_active`=1.
    - `logout` zeroes `data_out` and `digit_count` and returns to IDLE.
    - `digit_load` and `clear_entry` are ignored.
  - LOCKOUT:
    - `locked`=1 for `LOCKOUT_CYCLES` cycles.
    - Then clear the fail count and return to IDLE.
    - All inputs except `rst` are ignored.
- Input handling outside the states above:
  - `digit_load` is ignored in SEND, WAIT_RESP, GRANTED and LOCKOUT.
  - `access_grant_in` is ignored outside WAIT_RESP.
- Width rules:
  - Fail counter is 3 bits and saturates at `MAX_FAILS`.
  - Response counter is 8 bits; lockout counter is 16 bits.
  - Neither counter wraps; both count down to 0.
- `data_out` holds the complete word from SEND through WAIT_RESP and for the whole GRANTED session.

## Timing
- Reset values:
  - State IDLE.
  - `data_out`=0, `data_out_load`=0, `digit_count`=0.
  - `session_active`=0, `locked`=0.
  - Fail count and both counters 0.
- Reset mid-operation aborts any entry, session or lockout immediately.
- All outputs are registered.
- Digit 4 sampled at edge N:
  - `data_out` carries the full word and `data_out_load`=1 from edge N to edge N+1.
  - WAIT_RESP from edge N+1.
- Grant sampled high at edge M in WAIT_RESP: `session_active`=1 from edge M.
- No grant: the failure is taken at edge N+1+`RESP_WAIT`. `locked` or IDLE takes effect from that edge.
- Lockout entered at edge L: `locked` falls at edge L+`LOCKOUT_CYCLES`.
- `digit_count` updates on the same edge as the accepted strobe.
- Minimum spacing between `data_out_load` pulses is 6 cycles (four digits, then SEND, then at least one WAIT_RESP cycle).

## Test plan
- Grant path:
  - Stimulus: `user_id`=2'b01, digits 1,2,3,4; grant raised 3 cycles after the load.
  - Required: `data_out`=18'h11234, a single-cycle `data_out_load`, `session_active`=1 from the grant edge, `digit_count`=4.
- Reject path:
  - Stimulus: `user_id`=2'b00, digits A,B,C,D; no grant.
  - Required: `data_out`=18'h0ABCD during the wait; `session_active` stays 0 after 8 wait cycles; IDLE with `digit_count`=0.
- Lockout:
  - Stimulus: three rejected entries.
  - Required: `locked`=1 for exactly 16 cycles; `digit_load` strobes during lockout change nothing; afterwards a correct entry grants.
- Clear:
  - Stimulus: digits 5,6; then `clear_entry` and `digit_load` in the same cycle; then 4 new digits.
  - Required: count goes 2 to 0; the new word contains only the 4 new digits.
- Session:
  - Stimulus: digit strobes while GRANTED, then `logout`.
  - Required: strobes ignored and no `data_out_load`; after `logout`, `session_active`=0 and `data_out`=0.
- Reset:
  - Stimulus: assert `rst` low asynchronously mid-WAIT_RESP, and separately mid-lockout.
  - Required: all outputs 0 without waiting for a clock edge; fail count cleared.
